doodle_jump_engine: RTL and testbench
=====================================

Name: doodle_jump_engine

Overview:
Parametrised successor of the doodle jump/fall state machine. The block owns the doodle's vertical position, jump progress, screen scroll and score. It detects landings against a runtime-loadable table of NUM_PLATS platforms, scanning one entry per clock, so the platform layout is no longer hard-coded. It sits between the frame-tick generator and the VGA renderer, which consumes doodle_y, v_counter and score.

Parameters:
NUM_PLATS, 12, platform table depth (1..64)
COORD_W, 16, width of all coordinates, v_counter and score
JUMP_HEIGHT, 120, pixels of ascent per jump
DOODLE_RADIUS, 13, doodle half-size (centre to bottom/side edge)
PLAT_RADIUS_W, 32, platform half-width
PLAT_RADIUS_H, 7, platform half-height
V_MIDDLE, 275, screen row; the doodle never rises above it, the world scrolls instead
V_BOTTOM, 515, screen row; a doodle bottom below it ends the game
START_Y, 400, doodle centre row at Start

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous active-low reset
Start  in  1  begin game (sampled in I only)
Ack  in  1  leave DONE (sampled in DONE only)
tick  in  1  one-cycle frame-update strobe
vert_speed  in  4  pixels moved per tick
doodle_x  in  COORD_W  doodle centre column (screen coordinates)
plat_we  in  1  platform table write strobe
plat_idx  in  log2(NUM_PLATS)  write index
plat_x  in  COORD_W  platform centre column
plat_y  in  COORD_W  platform centre row (world coordinates)
plat_en  in  1  entry valid bit
q_I, q_Up, q_Down, q_Scan, q_Done  out  1 each  one-hot state flags
doodle_y  out  COORD_W  doodle centre row (screen coordinates)
v_counter  out  COORD_W  total pixels scrolled
score  out  COORD_W  accumulated score
is_in_middle  out  1  high on ticks where UP scrolled instead of moving
landed_idx  out  log2(NUM_PLATS)  index of the last platform landed on
overrun  out  1  sticky: a tick arrived while in SCAN

Behaviour:
- Reset (Reset_n=0 at a Clk edge, in any state, mid-scan included): state=I, doodle_y=START_Y, v_counter=0, score=0, up_count=0, is_in_middle=0, landed_idx=0, overrun=0, all plat_en cleared.
- Table writes: accepted in every state except SCAN, where they are ignored. Written on the clock edge; visible to the next scan.
- I: on Start -> UP, with doodle_y=START_Y and up_count=0.
- UP, on tick:
  - if doodle_y - vert_speed >= V_MIDDLE: doodle_y -= vert_speed, is_in_middle=0.
  - else: v_counter += vert_speed, score += vert_speed, is_in_middle=1.
  - up_count += vert_speed; if the new up_count >= JUMP_HEIGHT -> DOWN.
- DOWN, on tick: doodle_y += vert_speed, is_in_middle=0, then -> SCAN with scan index 0.
- SCAN: one table entry per cycle, no ticks consumed.
  - First cycle: if doodle_y + DOODLE_RADIUS > V_BOTTOM -> DONE; the bottom check has priority over landing.
  - Entry i hits when all of: plat_en[i]; doodle_x + DOODLE_RADIUS >= plat_x - PLAT_RADIUS_W; doodle_x - DOODLE_RADIUS <= plat_x + PLAT_RADIUS_W; doodle_y + DOODLE_RADIUS lies within [plat_y + v_counter - PLAT_RADIUS_H, plat_y + v_counter + PLAT_RADIUS_H], inclusive.
  - Lowest-index hit wins: -> UP, up_count=0, landed_idx=i.
  - No hit after entry NUM_PLATS-1 -> DOWN.
  - Worst-case latency is NUM_PLATS cycles.
- Arithmetic: all compares are done at COORD_W+2 bits signed, so subtraction cannot wrap. v_counter and score saturate at all-ones.
- tick in SCAN: dropped and overrun set to 1; overrun clears only on reset or on leaving DONE.
- DONE: outputs hold. On Ack -> I, clearing v_counter, score and overrun; the platform table is kept.
- Start outside I, Ack outside DONE: ignored. Ticks in I and DONE: ignored.
- vert_speed=0: ticks change no position, but state still steps DOWN -> SCAN.

Test Plan:
- Reset, Start, vert_speed=4, no platforms, 30 ticks -> doodle_y=280, up_count=120, state DOWN, v_counter=0.
- JUMP_HEIGHT=200, vert_speed=4, 50 ticks -> doodle_y=276 after tick 31; ticks 32-50 scroll, giving v_counter=76, score=76, is_in_middle=1; then DOWN.
- Platform 3 at (300,420) enabled, doodle_x=300, default params, speed 4: after ascent, the 30th fall tick brings doodle_y to 400 -> UP within 12 cycles, landed_idx=3.
- Two overlapping platforms, idx 2 and 7, both hit -> landed_idx=2. The same stack with doodle_x=360 (edge 347 > 332) -> no landing.
- No platforms, fall from 280 -> DONE when doodle_y reaches 504 (504+13 > 515); Ack -> I with v_counter=0 and table intact.
- tick pulsed mid-SCAN -> overrun=1 sticky. Reset_n low mid-SCAN for 1 cycle -> I with all outputs at reset values.

Source files
------------

// File: rtl/doodle_jump_engine_if.sv
// Platform-table write bus for doodle_jump_engine.
// The master (level loader / testbench) drives one entry per plat_we strobe.
//   plat_we  : write strobe
//   plat_idx : table index to write
//   plat_x   : platform centre column
//   plat_y   : platform centre row (world coordinates)
//   plat_en  : entry valid bit
interface doodle_jump_engine_if #(
  parameter int NUM_PLATS = 12,
  parameter int COORD_W   = 16,
  parameter int IDX_W     = (NUM_PLATS > 1) ? $clog2(NUM_PLATS) : 1
);
  logic               plat_we;
  logic [IDX_W-1:0]   plat_idx;
  logic [COORD_W-1:0] plat_x;
  logic [COORD_W-1:0] plat_y;
  logic               plat_en;

  modport master (output plat_we, plat_idx, plat_x, plat_y, plat_en);
  modport slave  (input  plat_we, plat_idx, plat_x, plat_y, plat_en);
endinterface

// File: rtl/doodle_jump_engine.sv
// Doodle jump/fall engine: owns the doodle's vertical position, jump
// progress, screen scroll and score, and detects landings against a
// runtime-loadable platform table scanned one entry per clock.
// Ports:
//   Clk, Reset_n        : clock, synchronous active-low reset
//   Start, Ack          : leave I / leave DONE
//   tick, vert_speed    : frame-update strobe and pixels per tick
//   doodle_x            : doodle centre column
//   plat_bus            : platform table write bus (slave)
//   q_I..q_Done         : one-hot state flags (registered)
//   doodle_y, v_counter : doodle row, total scroll
//   score, is_in_middle : score, "scrolled instead of moved" flag
//   landed_idx, overrun : last landed platform, sticky tick-in-scan flag
module doodle_jump_engine #(
  parameter int NUM_PLATS     = 12,
  parameter int COORD_W       = 16,
  parameter int JUMP_HEIGHT   = 120,
  parameter int DOODLE_RADIUS = 13,
  parameter int PLAT_RADIUS_W = 32,
  parameter int PLAT_RADIUS_H = 7,
  parameter int V_MIDDLE      = 275,
  parameter int V_BOTTOM      = 515,
  parameter int START_Y       = 400,
  parameter int IDX_W         = (NUM_PLATS > 1) ? $clog2(NUM_PLATS) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Ack,
  input  logic               tick,
  input  logic [3:0]         vert_speed,
  input  logic [COORD_W-1:0] doodle_x,
  doodle_jump_engine_if.slave plat_bus,
  output logic               q_I,
  output logic               q_Up,
  output logic               q_Down,
  output logic               q_Scan,
  output logic               q_Done,
  output logic [COORD_W-1:0] doodle_y,
  output logic [COORD_W-1:0] v_counter,
  output logic [COORD_W-1:0] score,
  output logic               is_in_middle,
  output logic [IDX_W-1:0]   landed_idx,
  output logic               overrun
);

  // Two guard bits keep every compare free of wrap-around.
  localparam int S = COORD_W + 2;
  typedef logic signed [S-1:0] sw_t;

  localparam sw_t R_D = sw_t'(DOODLE_RADIUS);
  localparam sw_t R_W = sw_t'(PLAT_RADIUS_W);
  localparam sw_t R_H = sw_t'(PLAT_RADIUS_H);
  localparam sw_t V_M = sw_t'(V_MIDDLE);
  localparam sw_t V_B = sw_t'(V_BOTTOM);
  localparam sw_t J_H = sw_t'(JUMP_HEIGHT);

  typedef enum logic [2:0] {S_I, S_UP, S_DOWN, S_SCAN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         flags_q, flags_d;
  logic [COORD_W-1:0] y_q, y_d, vc_q, vc_d, score_q, score_d, up_q, up_d;
  logic               mid_q, mid_d, ovr_q, ovr_d;
  logic [IDX_W-1:0]   landed_q, landed_d, scan_q, scan_d;
  logic [NUM_PLATS-1:0] plat_en_q, plat_en_d;
  logic [COORD_W-1:0] plat_x_q [NUM_PLATS];
  logic [COORD_W-1:0] plat_x_d [NUM_PLATS];
  logic [COORD_W-1:0] plat_y_q [NUM_PLATS];
  logic [COORD_W-1:0] plat_y_d [NUM_PLATS];

  function automatic logic [COORD_W-1:0] sat_add(input logic [COORD_W-1:0] a,
                                                  input logic [3:0] b);
    logic [COORD_W:0] s;
    s = {1'b0, a} + (COORD_W+1)'(b);
    return s[COORD_W] ? '1 : s[COORD_W-1:0];
  endfunction

  sw_t  bot, pyw, sp;
  logic hit;

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    vc_d      = vc_q;
    score_d   = score_q;
    up_d      = up_q;
    mid_d     = mid_q;
    ovr_d     = ovr_q;
    landed_d  = landed_q;
    scan_d    = scan_q;
    plat_en_d = plat_en_q;
    plat_x_d  = plat_x_q;
    plat_y_d  = plat_y_q;

    sp  = sw_t'(vert_speed);
    bot = sw_t'(y_q) + R_D;
    // Platform rows are world coordinates; shift by scroll to compare on screen.
    pyw = sw_t'(plat_y_q[scan_q]) + sw_t'(vc_q);
    hit = plat_en_q[scan_q]
       && (sw_t'(doodle_x) + R_D >= sw_t'(plat_x_q[scan_q]) - R_W)
       && (sw_t'(doodle_x) - R_D <= sw_t'(plat_x_q[scan_q]) + R_W)
       && (bot >= pyw - R_H) && (bot <= pyw + R_H);

    if (state_q != S_SCAN && plat_bus.plat_we && int'(plat_bus.plat_idx) < NUM_PLATS) begin
      plat_x_d[plat_bus.plat_idx]  = plat_bus.plat_x;
      plat_y_d[plat_bus.plat_idx]  = plat_bus.plat_y;
      plat_en_d[plat_bus.plat_idx] = plat_bus.plat_en;
    end

    case (state_q)
      S_I: if (Start) begin
        state_d = S_UP;
        y_d     = COORD_W'(START_Y);
        up_d    = '0;
      end
      S_UP: if (tick) begin
        if (sw_t'(y_q) - sp >= V_M) begin
          y_d   = y_q - COORD_W'(vert_speed);
          mid_d = 1'b0;
        end else begin
          vc_d    = sat_add(vc_q, vert_speed);
          score_d = sat_add(score_q, vert_speed);
          mid_d   = 1'b1;
        end
        up_d = up_q + COORD_W'(vert_speed);
        if (sw_t'(up_d) >= J_H) state_d = S_DOWN;
      end
      S_DOWN: if (tick) begin
        y_d     = y_q + COORD_W'(vert_speed);
        mid_d   = 1'b0;
        state_d = S_SCAN;
        scan_d  = '0;
      end
      S_SCAN: begin
        if (tick) ovr_d = 1'b1;
        // Index 0 only ever occurs on the first scan cycle, so it doubles as
        // the slot for the bottom check, which outranks any landing.
        if (scan_q == '0 && bot > V_B) begin
          state_d = S_DONE;
        end else if (hit) begin
          state_d  = S_UP;
          up_d     = '0;
          landed_d = scan_q;
        end else if (scan_q == IDX_W'(NUM_PLATS - 1)) begin
          state_d = S_DOWN;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      S_DONE: if (Ack) begin
        state_d = S_I;
        vc_d    = '0;
        score_d = '0;
        ovr_d   = 1'b0;
      end
      default: state_d = S_I;
    endcase

    flags_d = {state_d == S_DONE, state_d == S_SCAN, state_d == S_DOWN,
               state_d == S_UP, state_d == S_I};
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= S_I;
      flags_q   <= 5'b00001;
      y_q       <= COORD_W'(START_Y);
      vc_q      <= '0;
      score_q   <= '0;
      up_q      <= '0;
      mid_q     <= 1'b0;
      ovr_q     <= 1'b0;
      landed_q  <= '0;
      scan_q    <= '0;
      plat_en_q <= '0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      y_q       <= y_d;
      vc_q      <= vc_d;
      score_q   <= score_d;
      up_q      <= up_d;
      mid_q     <= mid_d;
      ovr_q     <= ovr_d;
      landed_q  <= landed_d;
      scan_q    <= scan_d;
      plat_en_q <= plat_en_d;
    end
  end

  // Coordinates need no reset: plat_en gates every use.
  always_ff @(posedge Clk) begin
    plat_x_q <= plat_x_d;
    plat_y_q <= plat_y_d;
  end

  assign {q_Done, q_Scan, q_Down, q_Up, q_I} = flags_q;
  assign doodle_y     = y_q;
  assign v_counter    = vc_q;
  assign score        = score_q;
  assign is_in_middle = mid_q;
  assign landed_idx   = landed_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_doodle_jump_engine.sv
// Self-checking bench for doodle_jump_engine: a reference model steps the
// game one frame tick at a time (a whole platform scan collapses into one
// search), pushes the expected outcome into a queue, and a monitor compares
// once the DUT has settled after each scored tick.
module tb_doodle_jump_engine;
  localparam int NP = 12;
  localparam int CW = 16;
  localparam int IW = 4;
  localparam int JH = 120, RD = 13, PRW = 32, PRH = 7, VM = 275, VB = 515, SY = 400;
  localparam int MAXV = (1 << CW) - 1;

  logic Clk = 0, Reset_n = 0, Start = 0, Ack = 0, tick = 0;
  logic [3:0] vert_speed = '0;
  logic [CW-1:0] doodle_x = '0;
  logic q_I, q_Up, q_Down, q_Scan, q_Done, is_in_middle, overrun;
  logic [CW-1:0] doodle_y, v_counter, score;
  logic [IW-1:0] landed_idx;
  bit scored = 0;

  doodle_jump_engine_if #(.NUM_PLATS(NP), .COORD_W(CW)) bus ();

  doodle_jump_engine #(.NUM_PLATS(NP), .COORD_W(CW), .JUMP_HEIGHT(JH),
    .DOODLE_RADIUS(RD), .PLAT_RADIUS_W(PRW), .PLAT_RADIUS_H(PRH),
    .V_MIDDLE(VM), .V_BOTTOM(VB), .START_Y(SY)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack), .tick(tick),
    .vert_speed(vert_speed), .doodle_x(doodle_x), .plat_bus(bus.slave),
    .q_I(q_I), .q_Up(q_Up), .q_Down(q_Down), .q_Scan(q_Scan), .q_Done(q_Done),
    .doodle_y(doodle_y), .v_counter(v_counter), .score(score),
    .is_in_middle(is_in_middle), .landed_idx(landed_idx), .overrun(overrun));

  always #5 Clk = ~Clk;

  // Model: st 0=idle 1=rising 2=falling 3=over
  int m_st, m_y, m_vc, m_sc, m_mid, m_ld, m_ov, m_climb, m_dx;
  int mx [NP], my [NP], men [NP];

  typedef struct {int st; int y; int vc; int sc; int mid; int ld; int ov;} snap_t;
  snap_t exp_q[$];
  int errors = 0, checks = 0;
  bit pend = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int dut_st();
    if (!$onehot({q_I, q_Up, q_Down, q_Scan, q_Done})) return 9;
    if (q_I) return 0;
    if (q_Up) return 1;
    if (q_Down) return 2;
    if (q_Done) return 3;
    return 4;
  endfunction

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_y = SY; m_vc = 0; m_sc = 0; m_mid = 0; m_ld = 0; m_ov = 0; m_climb = 0;
    foreach (men[i]) men[i] = 0;
  endtask

  task automatic model_tick(input int sp);
    int f;
    if (m_st == 1) begin
      if (m_y - sp >= VM) begin m_y -= sp; m_mid = 0; end
      else begin m_vc = sat(m_vc + sp); m_sc = sat(m_sc + sp); m_mid = 1; end
      m_climb += sp;
      if (m_climb >= JH) m_st = 2;
    end else if (m_st == 2) begin
      m_y += sp; m_mid = 0;
      if (m_y + RD > VB) m_st = 3;
      else begin
        f = -1;
        for (int i = 0; i < NP; i++)
          if (f < 0 && men[i] != 0 && m_dx + RD >= mx[i] - PRW && m_dx - RD <= mx[i] + PRW
              && m_y + RD >= my[i] + m_vc - PRH && m_y + RD <= my[i] + m_vc + PRH) f = i;
        if (f >= 0) begin m_st = 1; m_climb = 0; m_ld = f; end
      end
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.st = m_st; s.y = m_y; s.vc = m_vc; s.sc = m_sc; s.mid = m_mid; s.ld = m_ld; s.ov = m_ov;
    return s;
  endfunction

  // Monitor: a scored tick is answered once the DUT is out of its scan.
  initial begin
    int wcnt;
    snap_t e;
    wcnt = 0;
    forever begin
      @(posedge Clk);
      if (tick && scored) begin pend = 1; wcnt = 0; end
      @(negedge Clk);
      if (pend) begin
        wcnt++;
        if (!q_Scan) begin
          pend = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tick_resp: DUT response with empty expectation queue");
          end else begin
            e = exp_q.pop_front();
            if (dut_st() != e.st || int'(doodle_y) != e.y || int'(v_counter) != e.vc ||
                int'(score) != e.sc || int'(is_in_middle) != e.mid ||
                int'(landed_idx) != e.ld || int'(overrun) != e.ov) begin
              errors++;
              $display("FAIL tick_resp: got st=%0d y=%0d vc=%0d sc=%0d mid=%0d ld=%0d ov=%0d want st=%0d y=%0d vc=%0d sc=%0d mid=%0d ld=%0d ov=%0d",
                dut_st(), doodle_y, v_counter, score, is_in_middle, landed_idx, overrun,
                e.st, e.y, e.vc, e.sc, e.mid, e.ld, e.ov);
            end
          end
        end else if (wcnt > NP + 2) begin
          pend = 0;
          checks++; errors++;
          $display("FAIL scan_timeout: still scanning after %0d cycles, limit %0d", wcnt, NP + 2);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_tick(input int sp);
    model_tick(sp);
    exp_q.push_back(model_snap());
    @(negedge Clk); tick = 1; scored = 1; vert_speed = 4'(sp);
    @(negedge Clk); tick = 0; scored = 0;
    repeat (NP + 2) @(negedge Clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pend) && n < 60) begin @(negedge Clk); n++; end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic write_plat(input int idx, input int x, input int y, input int en);
    @(negedge Clk);
    bus.plat_we = 1; bus.plat_idx = IW'(idx); bus.plat_x = CW'(x); bus.plat_y = CW'(y);
    bus.plat_en = en[0];
    @(negedge Clk); bus.plat_we = 0;
    mx[idx] = x; my[idx] = y; men[idx] = en;
  endtask

  task automatic pulse_start();
    @(negedge Clk); Start = 1;
    @(negedge Clk); Start = 0;
    if (m_st == 0) begin m_st = 1; m_y = SY; m_climb = 0; end
  endtask

  task automatic pulse_ack();
    @(negedge Clk); Ack = 1;
    @(negedge Clk); Ack = 0;
    if (m_st == 3) begin m_st = 0; m_vc = 0; m_sc = 0; m_ov = 0; end
  endtask

  task automatic set_dx(input int x);
    doodle_x = CW'(x); m_dx = x;
  endtask

  task automatic do_reset();
    @(negedge Clk); Reset_n = 0;
    @(negedge Clk); Reset_n = 1;
    model_reset();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, dut_st(), 0);
    chk({tag, "_y"}, int'(doodle_y), SY);
    chk({tag, "_vc"}, int'(v_counter), 0);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_mid_ld_ov"}, int'({is_in_middle, landed_idx, overrun}), 0);
  endtask

  task automatic run_until(input int st, input int sp, input int limit);
    int n;
    n = 0;
    while (m_st != st && n < limit) begin do_tick(sp); n++; end
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.plat_we = 0; bus.plat_idx = '0; bus.plat_x = '0; bus.plat_y = '0; bus.plat_en = 0;
    model_reset();
    set_dx(0);
    repeat (2) @(negedge Clk);
    Reset_n = 1;
    check_reset("reset");

    // Platform 3 loaded early; it must survive the Ack of the first game.
    write_plat(3, 300, 420, 1);

    // Straight jump, then fall to the bottom with nothing under the doodle.
    pulse_start();
    chk("start_up", dut_st(), 1);
    for (int i = 0; i < 30; i++) do_tick(4);
    drain();
    chk("tp1_state_down", dut_st(), 2);
    chk("tp1_y", int'(doodle_y), 280);
    run_until(3, 4, 80);
    drain();
    chk("bottom_done", dut_st(), 3);
    chk("bottom_y", int'(doodle_y), 504);
    do_tick(4);                                // ticks in DONE are ignored
    pulse_ack();
    chk("ack_idle", dut_st(), 0);
    chk("ack_vc", int'(v_counter), 0);

    // Landing on platform 3, then a stack where the lowest index wins.
    set_dx(300);
    pulse_start();
    run_until(2, 4, 40);
    run_until(1, 4, 40);
    drain();
    chk("land_idx3", int'(landed_idx), 3);
    write_plat(2, 300, 420, 1);
    write_plat(7, 300, 420, 1);
    run_until(2, 4, 40);
    run_until(1, 4, 40);
    drain();
    chk("land_idx2", int'(landed_idx), 2);
    set_dx(360);                               // 347 > 332: off every platform
    run_until(3, 4, 120);
    drain();
    chk("edge_miss_done", dut_st(), 3);
    pulse_ack();

    // Tick and table write during a scan: tick dropped (overrun), write ignored.
    set_dx(0);
    pulse_start();
    run_until(2, 4, 40);
    drain();
    model_tick(4);
    m_ov = 1;
    exp_q.push_back(model_snap());
    @(negedge Clk); tick = 1; scored = 1; vert_speed = 4'd4;
    @(negedge Clk); tick = 0; scored = 0;
    chk("in_scan", int'(q_Scan), 1);
    tick = 1; bus.plat_we = 1; bus.plat_idx = '0; bus.plat_x = '0;
    bus.plat_y = CW'(m_y + RD - m_vc); bus.plat_en = 1;
    @(negedge Clk); tick = 0; bus.plat_we = 0;
    repeat (NP + 2) @(negedge Clk);
    drain();
    chk("overrun_sticky", int'(overrun), 1);
    do_tick(4);                                // would land on entry 0 had the write taken
    drain();

    // Reset in the middle of a scan.
    @(negedge Clk); tick = 1; vert_speed = 4'd4;
    @(negedge Clk); tick = 0;
    chk("reset_scan_pre", int'(q_Scan), 1);
    do_reset();
    check_reset("midscan_reset");

    // Table cleared by reset: same column that used to land now falls through.
    set_dx(300);
    pulse_start();
    run_until(3, 4, 120);
    drain();
    chk("cleared_done_y", int'(doodle_y), 504);
    pulse_ack();

    // Randomised games.
    for (int g = 0; g < 6; g++) begin
      if (g % 2 == 0)
        for (int i = 0; i < NP; i++)
          write_plat(i, 240 + $urandom_range(0, 120), $urandom_range(280, 520),
                     ($urandom_range(0, 9) < 7) ? 1 : 0);
      set_dx(280 + $urandom_range(0, 40));
      pulse_start();
      for (int t = 0; t < 250 && m_st != 3; t++) begin
        do_tick(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8));
        if ($urandom_range(0, 19) == 0) begin pulse_start(); pulse_ack(); end
      end
      if (m_st == 3) begin
        do_tick(3);
        drain();
        pulse_ack();
        chk("rand_ack_idle", dut_st(), 0);
      end else begin
        drain();
        do_reset();
        check_reset("rand_reset");
      end
    end

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
